operand_stack: RTL and testbench
================================

Name: operand_stack

Overview:
- Data stack that feeds the ALU and receives its result, directly upstream and downstream of the ALU in the stack-machine datapath.
- Holds TOS and NOS in dedicated registers, driven straight onto ALU operand inputs a and b; deeper entries live in an internal array.
- ALU output returns on data_in; the sequencer issues one stack op per cycle.
- Tracks depth and raises sticky overflow/underflow errors.

Parameters:
- WIDTH, 16, data word width (matches ALU a/b/out).
- DEPTH, 16, total entries including TOS and NOS; minimum 3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  3  stack operation, sampled every cycle (encoding below).
- data_in  in  WIDTH  value for PUSH/REPLACE/POP_REPLACE (ALU out or immediate).
- tos  out  WIDTH  top of stack, registered; drives ALU a.
- nos  out  WIDTH  next on stack, registered; drives ALU b.
- depth  out  $clog2(DEPTH+1)  number of valid entries.
- empty  out  1  depth==0, combinational from depth.
- full  out  1  depth==DEPTH, combinational from depth.
- ovf  out  1  sticky overflow error.
- udf  out  1  sticky underflow error.

Behaviour:
- Reset: tos=0, nos=0, depth=0, ovf=0, udf=0; array contents don't-care. Reset beats any op in the same cycle.
- op encoding; net depth change in brackets:
  - 000 NOP [0].
  - 001 PUSH [+1]: tos<=data_in, nos<=old tos, old nos into array.
  - 010 POP [-1]: tos<=old nos, nos<=array top.
  - 011 REPLACE [0]: tos<=data_in (unary ALU op).
  - 100 POP_REPLACE [-1]: tos<=data_in, nos<=array top (binary ALU op consumes a,b, leaves result).
  - 101 DUP [+1]: tos unchanged, nos<=old tos, old nos into array.
  - 110 POP2 [-2]: tos<=array top, nos<=array second.
  - 111 reserved: behaves as NOP.
- Latency: op in cycle N; tos/nos/depth reflect it after edge N+1. ALU result for cycle N+1 is combinational from the new tos/nos.
- Invalid slots: any slot at position >= depth reads as 0 on tos/nos. Popping into empty positions loads 0, never stale array data.
- Required depth per op:
  - REPLACE: >=1.
  - POP: >=1.
  - POP_REPLACE: >=2.
  - POP2: >=2.
  - DUP: >=1 and depth<DEPTH.
  - PUSH: depth<DEPTH.
- On violation:
  - op is fully suppressed; no state change other than the error flag.
  - Full-side violations set ovf; too-few-entries violations set udf. DUP on an empty stack sets udf.
- ovf/udf stay set until rst; ops after an error continue normally.
- Array addressing: array index = depth-3 for the entry below nos. No wrap-around: depth saturates by suppression, never modulo.
- Array is written on PUSH/DUP only when old depth>=2; otherwise old nos is 0/invalid and the array write is skipped.
- Width: depth never exceeds DEPTH; counter width sized to hold DEPTH exactly.

Test Plan:
- Reset, then PUSH 0xDEAD, PUSH 0xBEEF -> tos=0xBEEF, nos=0xDEAD, depth=2, empty=0, no errors.
- From that state, POP_REPLACE with data_in=0x9EAD -> tos=0x9EAD, nos=0, depth=1. Then REPLACE 0x2152 -> tos=0x2152, depth=1.
- PUSH 0x0001..0x0010 (16 values) -> full=1, tos=0x0010, nos=0x000F. 17th PUSH 0xCAFE -> tos=0x0010, depth=16, ovf=1. Then 16 POPs -> tos sequence 0x000F..0x0001 then 0, empty=1, ovf still 1.
- Reset, POP on empty -> udf=1, depth=0, tos=0. Then PUSH 0x1234 -> tos=0x1234, depth=1, udf=1. POP2 -> suppressed, depth=1, tos=0x1234.
- PUSH 0x00FE, DUP, POP2 -> after DUP tos=nos=0x00FE, depth=2. After POP2 depth=0, tos=nos=0.
- Assert rst in the same cycle as PUSH 0xAAAA at depth 5 -> next cycle depth=0, tos=0, nos=0, ovf=udf=0. Op 111 at depth 2 -> no state change.

Source files
------------

// File: rtl/operand_stack_if.sv
// Sequencer/ALU-facing bundle of the operand stack: op and data in, TOS/NOS and status out.
interface operand_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;

    modport master (
        output op, data_in,
        input  tos, nos, depth, empty, full, ovf, udf
    );

    modport slave (
        input  op, data_in,
        output tos, nos, depth, empty, full, ovf, udf
    );
endinterface

// File: rtl/operand_stack.sv
// ALU operand stack: TOS/NOS in registers feeding ALU a/b, deeper entries in an array,
// with depth tracking, op suppression on illegal depth and sticky overflow/underflow flags.
module operand_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    operand_stack_if.slave sif
);
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int ARR_N = DEPTH - 2;
    localparam int AW    = (ARR_N > 1) ? $clog2(ARR_N) : 1;

    localparam logic [2:0] OP_NOP         = 3'b000;
    localparam logic [2:0] OP_PUSH        = 3'b001;
    localparam logic [2:0] OP_POP         = 3'b010;
    localparam logic [2:0] OP_REPLACE     = 3'b011;
    localparam logic [2:0] OP_POP_REPLACE = 3'b100;
    localparam logic [2:0] OP_DUP         = 3'b101;
    localparam logic [2:0] OP_POP2        = 3'b110;

    logic [WIDTH-1:0] arr [0:ARR_N-1];

    logic [WIDTH-1:0] tos_reg, tos_next;
    logic [WIDTH-1:0] nos_reg, nos_next;
    logic [DW-1:0]    depth_reg, depth_next;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    second_idx;
    logic [WIDTH-1:0] rd_top;
    logic [WIDTH-1:0] rd_second;
    logic             at_least_1;
    logic             at_least_2;
    logic             is_full;

    // Entry directly below NOS sits at index depth-3; the push slot is depth-2.
    assign wr_idx     = AW'(depth_reg - DW'(2));
    assign top_idx    = AW'(depth_reg - DW'(3));
    assign second_idx = AW'(depth_reg - DW'(1) - DW'(3));

    // Slots beyond the valid depth must surface as 0, never as stale array data.
    assign rd_top    = (depth_reg > DW'(2)) ? arr[top_idx]    : '0;
    assign rd_second = (depth_reg > DW'(3)) ? arr[second_idx] : '0;

    assign at_least_1 = (depth_reg != '0);
    assign at_least_2 = (depth_reg > DW'(1));
    assign is_full    = (depth_reg == DW'(DEPTH));

    always_comb begin
        tos_next   = tos_reg;
        nos_next   = nos_reg;
        depth_next = depth_reg;
        ovf_next   = ovf_reg;
        udf_next   = udf_reg;
        wr_en      = 1'b0;
        unique case (sif.op)
            OP_PUSH: begin
                if (is_full) begin
                    ovf_next = 1'b1;
                end else begin
                    tos_next   = sif.data_in;
                    nos_next   = tos_reg;
                    depth_next = depth_reg + DW'(1);
                    wr_en      = at_least_2;
                end
            end
            OP_POP: begin
                if (!at_least_1) begin
                    udf_next = 1'b1;
                end else begin
                    tos_next   = nos_reg;
                    nos_next   = rd_top;
                    depth_next = depth_reg - DW'(1);
                end
            end
            OP_REPLACE: begin
                if (!at_least_1) udf_next = 1'b1;
                else             tos_next = sif.data_in;
            end
            OP_POP_REPLACE: begin
                if (!at_least_2) begin
                    udf_next = 1'b1;
                end else begin
                    tos_next   = sif.data_in;
                    nos_next   = rd_top;
                    depth_next = depth_reg - DW'(1);
                end
            end
            OP_DUP: begin
                // Empty check wins: duplicating nothing is an underflow, not an overflow.
                if (!at_least_1) begin
                    udf_next = 1'b1;
                end else if (is_full) begin
                    ovf_next = 1'b1;
                end else begin
                    nos_next   = tos_reg;
                    depth_next = depth_reg + DW'(1);
                    wr_en      = at_least_2;
                end
            end
            OP_POP2: begin
                if (!at_least_2) begin
                    udf_next = 1'b1;
                end else begin
                    tos_next   = rd_top;
                    nos_next   = rd_second;
                    depth_next = depth_reg - DW'(2);
                end
            end
            default: ; // NOP and the reserved code leave state untouched
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_reg   <= '0;
            nos_reg   <= '0;
            depth_reg <= '0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            tos_reg   <= tos_next;
            nos_reg   <= nos_next;
            depth_reg <= depth_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            arr[wr_idx] <= nos_reg;
        end
    end

    assign sif.tos   = tos_reg;
    assign sif.nos   = nos_reg;
    assign sif.depth = depth_reg;
    assign sif.empty = (depth_reg == '0);
    assign sif.full  = is_full;
    assign sif.ovf   = ovf_reg;
    assign sif.udf   = udf_reg;
endmodule

// File: tb/tb_operand_stack.sv
// Directed test of operand_stack: hand-computed TOS/NOS/depth/flag expectations per op.
module tb_operand_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] PUSH  = 3'b001;
    localparam logic [2:0] POP   = 3'b010;
    localparam logic [2:0] REPL  = 3'b011;
    localparam logic [2:0] POPR  = 3'b100;
    localparam logic [2:0] DUP   = 3'b101;
    localparam logic [2:0] POP2  = 3'b110;
    localparam logic [2:0] RSVD  = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    operand_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) sif ();

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] data);
        @(negedge clk);
        sif.op      = op;
        sif.data_in = data;
        @(posedge clk);
        #1;
        sif.op      = NOP;
        sif.data_in = '0;
        $display("op=%0d data=0x%04h -> tos=0x%04h nos=0x%04h depth=%0d ovf=%0b udf=%0b",
                 op, data, sif.tos, sif.nos, sif.depth, sif.ovf, sif.udf);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        sif.op = NOP;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        sif.op      = NOP;
        sif.data_in = '0;
        do_reset();

        // Reset state
        check("rst_tos",   32'(sif.tos),   32'h0);
        check("rst_nos",   32'(sif.nos),   32'h0);
        check("rst_depth", 32'(sif.depth), 32'd0);
        check("rst_empty", 32'(sif.empty), 32'd1);
        check("rst_full",  32'(sif.full),  32'd0);
        check("rst_ovf",   32'(sif.ovf),   32'd0);
        check("rst_udf",   32'(sif.udf),   32'd0);

        // Two pushes, binary and unary ALU ops
        do_op(PUSH, 16'hDEAD);
        do_op(PUSH, 16'hBEEF);
        check("p2_tos",   32'(sif.tos),   32'hBEEF);
        check("p2_nos",   32'(sif.nos),   32'hDEAD);
        check("p2_depth", 32'(sif.depth), 32'd2);
        check("p2_empty", 32'(sif.empty), 32'd0);
        check("p2_err",   32'({sif.ovf, sif.udf}), 32'd0);
        do_op(POPR, 16'h9EAD);
        check("popr_tos",   32'(sif.tos),   32'h9EAD);
        check("popr_nos",   32'(sif.nos),   32'h0);
        check("popr_depth", 32'(sif.depth), 32'd1);
        do_op(REPL, 16'h2152);
        check("repl_tos",   32'(sif.tos),   32'h2152);
        check("repl_depth", 32'(sif.depth), 32'd1);

        // Fill to DEPTH, overflow, then drain through the array
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            do_op(PUSH, WIDTH'(i));
            check("fill_tos", 32'(sif.tos), 32'(i));
        end
        check("fill_full",  32'(sif.full),  32'd1);
        check("fill_nos",   32'(sif.nos),   32'h000F);
        check("fill_depth", 32'(sif.depth), 32'd16);
        do_op(PUSH, 16'hCAFE);
        check("ovf_tos",   32'(sif.tos),   32'h0010);
        check("ovf_nos",   32'(sif.nos),   32'h000F);
        check("ovf_depth", 32'(sif.depth), 32'd16);
        check("ovf_flag",  32'(sif.ovf),   32'd1);
        do_op(DUP, 16'h0);
        check("dupfull_depth", 32'(sif.depth), 32'd16);
        check("dupfull_tos",   32'(sif.tos),   32'h0010);
        for (int k = 1; k <= DEPTH; k++) begin
            do_op(POP, 16'h0);
            check("drain_tos",   32'(sif.tos),   32'(DEPTH - k));
            check("drain_nos",   32'(sif.nos),   (k <= 15) ? 32'(15 - k) : 32'd0);
            check("drain_depth", 32'(sif.depth), 32'(DEPTH - k));
        end
        check("drain_empty", 32'(sif.empty), 32'd1);
        check("drain_ovf",   32'(sif.ovf),   32'd1);
        check("drain_udf",   32'(sif.udf),   32'd0);

        // Underflow cases
        do_reset();
        do_op(POP, 16'h0);
        check("udf_flag",  32'(sif.udf),   32'd1);
        check("udf_depth", 32'(sif.depth), 32'd0);
        check("udf_tos",   32'(sif.tos),   32'h0);
        do_op(PUSH, 16'h1234);
        check("udfp_tos",   32'(sif.tos),   32'h1234);
        check("udfp_depth", 32'(sif.depth), 32'd1);
        check("udfp_udf",   32'(sif.udf),   32'd1);
        do_op(POP2, 16'h0);
        check("pop2s_depth", 32'(sif.depth), 32'd1);
        check("pop2s_tos",   32'(sif.tos),   32'h1234);
        do_op(POPR, 16'h7777);
        check("poprs_depth", 32'(sif.depth), 32'd1);
        check("poprs_tos",   32'(sif.tos),   32'h1234);

        do_reset();
        do_op(DUP, 16'h0);
        check("dupe_udf",   32'(sif.udf),   32'd1);
        check("dupe_ovf",   32'(sif.ovf),   32'd0);
        check("dupe_depth", 32'(sif.depth), 32'd0);

        // DUP then POP2 back to empty
        do_reset();
        do_op(PUSH, 16'h00FE);
        do_op(DUP, 16'h0);
        check("dup_tos",   32'(sif.tos),   32'h00FE);
        check("dup_nos",   32'(sif.nos),   32'h00FE);
        check("dup_depth", 32'(sif.depth), 32'd2);
        do_op(POP2, 16'h0);
        check("pop2_depth", 32'(sif.depth), 32'd0);
        check("pop2_tos",   32'(sif.tos),   32'h0);
        check("pop2_nos",   32'(sif.nos),   32'h0);

        // POP2 pulling two entries from the array
        do_op(PUSH, 16'h0A01);
        do_op(PUSH, 16'h0A02);
        do_op(PUSH, 16'h0A03);
        do_op(PUSH, 16'h0A04);
        do_op(POP2, 16'h0);
        check("pop2a_tos",   32'(sif.tos),   32'h0A02);
        check("pop2a_nos",   32'(sif.nos),   32'h0A01);
        check("pop2a_depth", 32'(sif.depth), 32'd2);

        // Reset beats a simultaneous PUSH
        do_reset();
        for (int i = 1; i <= 5; i++) do_op(PUSH, WIDTH'(i));
        do_op(POP, 16'h0);
        do_op(POP, 16'h0);
        do_op(POP, 16'h0);
        do_op(POP, 16'h0);
        do_op(POP, 16'h0);
        do_op(POP, 16'h0);
        for (int i = 1; i <= 5; i++) do_op(PUSH, WIDTH'(i));
        check("pre_rst_depth", 32'(sif.depth), 32'd5);
        @(negedge clk);
        rst         = 1'b1;
        sif.op      = PUSH;
        sif.data_in = 16'hAAAA;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        sif.op      = NOP;
        sif.data_in = '0;
        $display("rst+PUSH 0xAAAA -> tos=0x%04h depth=%0d", sif.tos, sif.depth);
        check("rstp_depth", 32'(sif.depth), 32'd0);
        check("rstp_tos",   32'(sif.tos),   32'h0);
        check("rstp_nos",   32'(sif.nos),   32'h0);
        check("rstp_err",   32'({sif.ovf, sif.udf}), 32'd0);

        // Reserved op is a NOP
        do_op(PUSH, 16'h0011);
        do_op(PUSH, 16'h0022);
        do_op(RSVD, 16'h5555);
        check("rsvd_tos",   32'(sif.tos),   32'h0022);
        check("rsvd_nos",   32'(sif.nos),   32'h0011);
        check("rsvd_depth", 32'(sif.depth), 32'd2);
        check("rsvd_err",   32'({sif.ovf, sif.udf}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
